// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with a fixed-latency valid/ready responder.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned/reserved-size requests instead of forcing alignment.
module data_mem_responder #(
    parameter int BITNESS    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [BITNESS-1:0] req_addr_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_unsigned_i,
    input  logic [BITNESS-1:0] req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [BITNESS-1:0] rsp_rdata_o,
    output logic               rsp_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              mem_q [0:(2**ADDR_WIDTH)-1];

    logic                    we_q, uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic [BITNESS-1:0]      wdata_q;

    logic                    cur_we, cur_uns;
    logic [ADDR_WIDTH-1:0]   cur_addr, base;
    logic [1:0]              cur_size, eff_size;
    logic [BITNESS-1:0]      cur_wdata;
    logic                    mis_err;
    logic [3:0]              be;
    logic [31:0]             raw;
    logic                    enter_resp;
    logic [BITNESS-1:0]      rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[BITNESS-1:ADDR_WIDTH];

    function automatic logic [BITNESS-1:0] extend_load(input logic [31:0] r,
                                                       input logic [1:0]  size,
                                                       input logic        uns);
        logic signed [7:0]         b;
        logic signed [15:0]        h;
        logic signed [31:0]        w;
        logic signed [BITNESS-1:0] ext;
        b = $signed(r[7:0]);
        h = $signed(r[15:0]);
        w = $signed(r);
        case (size)
            2'b00:   ext = uns ? BITNESS'(r[7:0])  : BITNESS'(b);
            2'b01:   ext = uns ? BITNESS'(r[15:0]) : BITNESS'(h);
            default: ext = uns ? BITNESS'(r)       : BITNESS'(w);
        endcase
        return ext;
    endfunction

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (req_valid_i && req_ready_o) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i[ADDR_WIDTH-1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
        end
    end

    // With LATENCY=1 the access happens on the handshake edge itself, so use the live request then.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we_i;
            cur_addr  = req_addr_i[ADDR_WIDTH-1:0];
            cur_size  = req_size_i;
            cur_uns   = req_unsigned_i;
            cur_wdata = req_wdata_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        base     = cur_addr;
`ifdef DMEM_ALIGN_CHECK_EN
        eff_size = cur_size;
        mis_err  = (cur_size == 2'b11) ||
                   (cur_size == 2'b01 && cur_addr[0]) ||
                   (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
`else
        mis_err  = 1'b0;
        eff_size = (cur_size == 2'b11) ? 2'b10 : cur_size;
        if (eff_size == 2'b01) base[0]   = 1'b0;
        if (eff_size == 2'b10) base[1:0] = 2'b00;
`endif
        case (eff_size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < 4; k++) begin
            raw[8*k +: 8] = mem_q[base + ADDR_WIDTH'(k)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (enter_resp && cur_we && !mis_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem_q[base + ADDR_WIDTH'(k)] <= cur_wdata[8*k +: 8];
            end
        end
    end

    // Response payload is captured once on entry to RESP and held until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q   <= mis_err;
            rsp_rdata_q <= (cur_we || mis_err) ? '0 : extend_load(raw, eff_size, cur_uns);
        end
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference memory predicts each response.
// Expectations follow DMEM_ALIGN_CHECK_EN when the bench is compiled with it.
module tb_data_mem_responder;
    localparam int BITNESS    = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int LATENCY    = 2;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic               req_we_i = 1'b0;
    logic [BITNESS-1:0] req_addr_i = '0;
    logic [1:0]         req_size_i = 2'b00;
    logic               req_unsigned_i = 1'b0;
    logic [BITNESS-1:0] req_wdata_i = '0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b0;
    logic [BITNESS-1:0] rsp_rdata_o;
    logic               rsp_err_o;

    always #5 clk_i = ~clk_i;

    data_mem_responder #(
        .BITNESS(BITNESS), .ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem_m [1024];
    exp_t        sb_q[$];
    logic [31:0] last_rdata;
    logic        last_err;
    time         hs_t;

    // Reference model: compute the expected response and apply stores to mem_m.
    function automatic void model_push(input logic we, input logic [31:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wdata);
        exp_t        e;
        logic [9:0]  a;
        logic [1:0]  sz;
        logic [31:0] r;
        int          nb;
        a  = addr[9:0];
        sz = size;
`ifdef DMEM_ALIGN_CHECK_EN
        e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
        e.err = 1'b0;
        if (sz == 2'd3) sz = 2'd2;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
`endif
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int k = 0; k < nb; k++) mem_m[10'(a + k)] = wdata[8*k +: 8];
            end else begin
                r = {mem_m[10'(a + 3)], mem_m[10'(a + 2)], mem_m[10'(a + 1)], mem_m[a]};
                if (nb == 1)      e.rdata = uns ? {24'h0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
                else if (nb == 2) e.rdata = uns ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
                else              e.rdata = r;
            end
        end
        sb_q.push_back(e);
    endfunction

    // One transaction; hold = cycles rsp_ready_i stays low in RESP, junk = keep req_valid_i high meanwhile.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int hold, input logic junk);
        int          n;
        int          lat;
        exp_t        e;
        logic [31:0] hd;
        logic        he;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_size_i = size; req_unsigned_i = uns; req_wdata_i = wdata;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk_i); n++; end
        if (!req_ready_o) begin
            checks++; failures++;
            $display("FAIL req_ready_timeout got=%0b want=1", req_ready_o);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        hs_t = $time;
        model_push(we, addr, size, uns, wdata);
        #1;
        req_valid_i = junk; req_we_i = 1'($urandom()); req_addr_i = $urandom();
        req_size_i = 2'($urandom()); req_unsigned_i = 1'($urandom()); req_wdata_i = $urandom();
        lat = 0;
        do begin @(negedge clk_i); lat++; end while (!rsp_valid_o && lat < 20);
        checks++;
        if (lat != LATENCY) begin
            failures++;
            $display("FAIL rsp_latency got=%0d want=%0d", lat, LATENCY);
        end
        e = sb_q.pop_front();
        if (!rsp_valid_o) begin
            req_valid_i = 1'b0;
            return;
        end
        hd = rsp_rdata_o; he = rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== hd || rsp_err_o !== he || req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold cycle=%0d got valid=%0b rdata=%h err=%0b rdy=%0b want 1/%h/%0b/0",
                         i, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o, hd, he);
            end
        end
        checks++;
        if (rsp_rdata_o !== e.rdata) begin
            failures++;
            $display("FAIL rsp_rdata addr=%h got=%h want=%h", addr, rsp_rdata_o, e.rdata);
        end
        checks++;
        if (rsp_err_o !== e.err) begin
            failures++;
            $display("FAIL rsp_err addr=%h got=%0b want=%0b", addr, rsp_err_o, e.err);
        end
        last_rdata = rsp_rdata_o; last_err = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL after_accept got valid=%0b rdy=%0b want 0/1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b rdata=%h err=%0b want 0/0/0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b want=1", req_ready_o);
        end
    endtask

    task automatic test_word_rw();
        do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_load got=%h want=deadbeef", last_rdata);
        end
    endtask

    task automatic test_byte_ext();
        do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        do_txn(1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 0, 1'b0);
        do_txn(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL byte_signed got=%h want=ffffff80", last_rdata);
        end
        do_txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'h00000080) begin
            failures++;
            $display("FAIL byte_unsigned got=%h want=00000080", last_rdata);
        end
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'h80000000) begin
            failures++;
            $display("FAIL byte_word_view got=%h want=80000000", last_rdata);
        end
        do_txn(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'hFFFF8000) begin
            failures++;
            $display("FAIL half_signed got=%h want=ffff8000", last_rdata);
        end
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        time t1;
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        t1 = hs_t;
        do_txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, 1'b0);
        checks++;
        if (hs_t - t1 != time'((LATENCY + 1) * 10)) begin
            failures++;
            $display("FAIL b2b_spacing got=%0t want=%0d", hs_t - t1, (LATENCY + 1) * 10);
        end
    endtask

    task automatic test_align();
        do_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'h01020304, 0, 1'b0);
        do_txn(1'b1, 32'h11, 2'b10, 1'b0, 32'hCAFEF00D, 0, 1'b0);
        do_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        checks++;
        if (last_rdata !== 32'h01020304) begin
            failures++;
            $display("FAIL align_no_write got=%h want=01020304", last_rdata);
        end
`else
        checks++;
        if (last_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL align_forced got=%h want=cafef00d", last_rdata);
        end
`endif
        do_txn(1'b0, 32'h13, 2'b01, 1'b1, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h12, 2'b11, 1'b0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_txn(1'b1, 32'h400, 2'b10, 1'b0, 32'h12345678, 0, 1'b0);
        do_txn(1'b0, 32'h000, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL wrap_load got=%h want=12345678", last_rdata);
        end
    endtask

    task automatic test_reset_wait();
        do_txn(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 0, 1'b0);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20;
        req_size_i = 2'b10; req_unsigned_i = 1'b0; req_wdata_i = 32'hAAAAAAAA;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_wait got valid=%0b rdy=%0b want 0/1", rsp_valid_o, req_ready_o);
        end
        do_txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        checks++;
        if (last_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL reset_store_dropped got=%h want=11223344", last_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            do_txn(1'b1, 32'h40 + 32'(i * 4), 2'b10, 1'b0, $urandom(), 0, 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            a = 32'h40 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 10);
            do_txn(1'($urandom()), a, 2'($urandom()), 1'($urandom()), $urandom(),
                   int'($urandom_range(0, 2)), 1'($urandom()));
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_ext();
        test_backpressure();
        test_back_to_back();
        test_align();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter BITNESS, 32, data/address width in bits.
REQ-002 Parameter ADDR_WIDTH, 10, byte-address bits decoded; memory depth 2**ADDR_WIDTH bytes.
REQ-003 Parameter LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 req_valid_i  input  1  load/store request present.
REQ-007 req_ready_o  output  1  responder can accept a request.
REQ-008 req_we_i  input  1  1 = store, 0 = load.
REQ-009 req_addr_i  input  BITNESS  byte address.
REQ-010 req_size_i  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-011 req_unsigned_i  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-012 req_wdata_i  input  BITNESS  store data, right-aligned.
REQ-013 rsp_valid_o  output  1  response present.
REQ-014 rsp_ready_i  input  1  requester accepts response.
REQ-015 rsp_rdata_o  output  BITNESS  extended load data; 0 for stores and errors.
REQ-016 rsp_err_o  output  1  request was misaligned or used reserved size.

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i & req_ready_o on a rising edge.
REQ-019 On handshake, all request fields SHALL be registered; if LATENCY=1, next state RESP, else WAIT with counter loaded LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; on reaching 1, next state RESP, so rsp_valid_o rises exactly LATENCY cycles after the handshake edge.
REQ-021 Memory SHALL be byte-addressed little-endian; only req_addr_i[ADDR_WIDTH-1:0] decoded, upper bits ignored (aliasing/wrap-around).
REQ-022 Store writes and load data capture SHALL occur on the edge entering RESP; stores write only the addressed 1/2/4 bytes from low bits of wdata.
REQ-023 Loads SHALL extend byte/halfword per req_unsigned_i; word loads unchanged.
REQ-024 In RESP, rsp_valid_o, rsp_rdata_o, rsp_err_o SHALL hold stable until rsp_valid_o & rsp_ready_i, then next state IDLE; rsp_ready_i outside RESP ignored.
REQ-025 Max throughput SHALL be one request per LATENCY+1 cycles (IDLE cycle between transactions).
REQ-026 req_valid_i changes outside IDLE SHALL have no effect; registered request fields SHALL not change until return to IDLE.
REQ-027 Store followed by load to the same address SHALL return the stored data.

Reset
REQ-028 While rst_i=1 at an edge: state IDLE, counter 0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; req_ready_o=1 after release.
REQ-029 Reset in WAIT SHALL discard the pending request; an uncommitted store SHALL NOT modify memory.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1, word with addr[1:0]!=00, or size 11 SHALL set rsp_err_o=1, rdata 0, no memory write, same latency.
REQ-032 Macro DMEM_ALIGN_CHECK_EN undefined: rsp_err_o SHALL tie to 0; address low bits SHALL be forced to alignment (halfword clears bit0, word clears bits1:0); size 11 treated as word.

Verification
REQ-033 Reset, store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata_o=0xDEADBEEF, rsp_valid_o rises exactly 2 cycles after each handshake (LATENCY=2).
REQ-034 Store byte 0x80 @0x13 over word 0x00000000 @0x10; load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80000000.
REQ-035 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and data stable, req_ready_o=0; after accept, req_ready_o=1 next cycle.
REQ-036 With DMEM_ALIGN_CHECK_EN: store word @0x11 -> rsp_err_o=1, then load word @0x10 returns prior contents unchanged; without macro, same store writes @0x10, rsp_err_o=0.
REQ-037 Store word 0x12345678 @0x400 (ADDR_WIDTH=10) -> load @0x000 returns 0x12345678 (wrap).
REQ-038 Assert rst_i during WAIT of store 0xAAAAAAAA @0x20 -> rsp_valid_o=0 next cycle; later load @0x20 returns prior value.
